conv_maxpool2x2: RTL



---
 rtl/conv_maxpool2x2_if.sv | 30 +++
 rtl/conv_maxpool2x2.sv | 111 +++++++++++
 2 files changed

// File: rtl/conv_maxpool2x2_if.sv
// Stream bundle between the convolution neuron, the 2x2 max-pool stage and
// the next layer. The pool stage is the slave: it receives in_* and drives out_*.
// Handshake: in_valid qualifies in_stream for one cycle and is never stalled.
// out_valid is a one-cycle pulse qualifying out_stream and out_last, and the
// consumer must accept every pulse.
interface conv_maxpool2x2_if #(
   parameter int DATA_WIDTH = 8
) ();
   logic [DATA_WIDTH-1:0] in_stream;
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] out_stream;
   logic                  out_valid;
   logic                  out_last;

   modport slave (
      input  in_stream,
      input  in_valid,
      output out_stream,
      output out_valid,
      output out_last
   );

   modport master (
      output in_stream,
      output in_valid,
      input  out_stream,
      input  out_valid,
      input  out_last
   );
endinterface

// File: rtl/conv_maxpool2x2.sv
// 2x2 stride-2 max pooling over a raster-order feature map stream.
// Even rows are reduced to horizontal pair maxima and parked in a half-width
// line buffer. Odd rows combine their pair maximum with the parked value and
// emit one pooled result one cycle after the window's bottom-right input.
module conv_maxpool2x2 #(
   parameter int    DATA_WIDTH = 8,
   parameter int    IMG_WIDTH  = 28,
   parameter int    IMG_HEIGHT = 28,
   parameter string SIGNED     = "FALSE"
) (
   input  logic clk,
   input  logic rst,
   conv_maxpool2x2_if.slave bus
);

   localparam int HALF_W = IMG_WIDTH / 2;
   localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
   localparam int COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam bit IS_SIGNED = (SIGNED == "TRUE");

   localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);

   // Larger of two values under the configured number interpretation.
   function automatic logic [DATA_WIDTH-1:0] vmax(
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b
   );
      logic a_gt;
      if (IS_SIGNED) a_gt = ($signed(a) > $signed(b));
      else           a_gt = (a > b);
      return a_gt ? a : b;
   endfunction

   logic [COL_W-1:0]      col_q, col_d;
   logic [ROW_W-1:0]      row_q, row_d;
   logic [DATA_WIDTH-1:0] pair_q, pair_d;
   logic [DATA_WIDTH-1:0] out_stream_q, out_stream_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q, out_last_d;

   // Line buffer holds one pair maximum per window column; never reset,
   // since every entry is written on an even row before the odd row reads it.
   logic [DATA_WIDTH-1:0] linebuf [HALF_W];
   logic [IDX_W-1:0]      lb_idx;
   logic                  lb_we;
   logic [DATA_WIDTH-1:0] lb_rdata;
   logic [DATA_WIDTH-1:0] pmax;

   assign lb_idx   = IDX_W'(col_q >> 1);
   assign lb_rdata = linebuf[lb_idx];
   assign pmax     = vmax(pair_q, bus.in_stream);

   // Position tracking, pair capture, line buffer write and output formation.
   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      pair_d       = pair_q;
      out_stream_d = out_stream_q;
      out_valid_d  = 1'b0;
      out_last_d   = 1'b0;
      lb_we        = 1'b0;
      if (bus.in_valid) begin
         if (col_q == COL_MAX) begin
            col_d = '0;
            row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
         if (!col_q[0]) begin
            pair_d = bus.in_stream;
         end else if (!row_q[0]) begin
            lb_we = 1'b1;
         end else begin
            out_valid_d  = 1'b1;
            out_stream_d = vmax(pmax, lb_rdata);
            out_last_d   = (row_q == ROW_MAX) && (col_q == COL_MAX);
         end
      end
   end

   // State and output registers; reset also drops a coincident input.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         pair_q       <= '0;
         out_stream_q <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         pair_q       <= pair_d;
         out_stream_q <= out_stream_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
      end
   end

   // Even-row pair maxima parked for the following odd row.
   always_ff @(posedge clk) begin
      if (lb_we && !rst) linebuf[lb_idx] <= pmax;
   end

   assign bus.out_stream = out_stream_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_last   = out_last_q;

endmodule
